// File: rtl/rl_lj_pair_tag_pipeline_if.sv
// rl_lj_pair_tag_pipeline_if: pair tag entry, force pipeline result and aligned output bundle
interface rl_lj_pair_tag_pipeline_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int CNT_WIDTH = 7,
  parameter int PAIR_CNT_WIDTH = 16
);
  logic in_valid;
  logic [PARTICLE_ID_WIDTH-1:0] in_ref_id, in_nb_id;
  logic pipe_out_valid;
  logic [DATA_WIDTH-1:0] pipe_force_x, pipe_force_y, pipe_force_z;
  logic out_valid;
  logic [PARTICLE_ID_WIDTH-1:0] out_ref_id, out_nb_id;
  logic [DATA_WIDTH-1:0] out_force_x, out_force_y, out_force_z;
  logic out_ref_switch;
  logic [PAIR_CNT_WIDTH-1:0] out_pair_count;
  logic [CNT_WIDTH-1:0] in_flight_count;
  logic pipe_empty;
  logic misalign_error;
  modport master (
    output in_valid, in_ref_id, in_nb_id, pipe_out_valid, pipe_force_x, pipe_force_y, pipe_force_z,
    input out_valid, out_ref_id, out_nb_id, out_force_x, out_force_y, out_force_z,
    input out_ref_switch, out_pair_count, in_flight_count, pipe_empty, misalign_error
  );
  modport slave (
    input in_valid, in_ref_id, in_nb_id, pipe_out_valid, pipe_force_x, pipe_force_y, pipe_force_z,
    output out_valid, out_ref_id, out_nb_id, out_force_x, out_force_y, out_force_z,
    output out_ref_switch, out_pair_count, in_flight_count, pipe_empty, misalign_error
  );
endinterface

// File: rtl/rl_lj_pair_tag_pipeline.sv
// rl_lj_pair_tag_pipeline: delays pair IDs alongside the LJ force pipeline and rejoins them with its result
module rl_lj_pair_tag_pipeline #(
  parameter int DATA_WIDTH = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int PIPE_LATENCY = 14,
  parameter int CNT_WIDTH = 7,
  parameter int PAIR_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  rl_lj_pair_tag_pipeline_if.slave bus
);
  localparam int IW = PARTICLE_ID_WIDTH;
  logic [PIPE_LATENCY-1:0] tag_v;
  logic [2*IW-1:0] tag_id [PIPE_LATENCY];
  logic [IW-1:0] tail_ref, tail_nb, last_ref;
  logic tail_v, emit, new_ref, first;
  logic [CNT_WIDTH-1:0] cnt;
  assign tail_v = tag_v[PIPE_LATENCY-1];
  assign {tail_ref, tail_nb} = tag_id[PIPE_LATENCY-1];
  assign emit = tail_v & bus.pipe_out_valid;
  assign new_ref = first | (tail_ref != last_ref);
  assign bus.in_flight_count = cnt;
  assign bus.pipe_empty = cnt == '0;
  // ID stages carry no reset; only the valid bits decide whether a tag is live
  always_ff @(posedge clk) begin
    tag_id[0] <= {bus.in_ref_id, bus.in_nb_id};
    for (int i = 1; i < PIPE_LATENCY; i++) tag_id[i] <= tag_id[i-1];
  end
  always_ff @(posedge clk)
    if (rst) begin
      tag_v <= '0;
      cnt <= '0;
      first <= 1'b1;
      last_ref <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ref_switch <= 1'b0;
      bus.out_ref_id <= '0;
      bus.out_nb_id <= '0;
      bus.out_force_x <= '0;
      bus.out_force_y <= '0;
      bus.out_force_z <= '0;
      bus.out_pair_count <= '0;
      bus.misalign_error <= 1'b0;
    end else begin
      tag_v[0] <= bus.in_valid;
      for (int i = 1; i < PIPE_LATENCY; i++) tag_v[i] <= tag_v[i-1];
      cnt <= cnt + CNT_WIDTH'(bus.in_valid) - CNT_WIDTH'(tail_v);
      bus.out_valid <= emit;
      bus.out_ref_switch <= emit & new_ref;
      bus.out_ref_id <= tail_ref;
      bus.out_nb_id <= tail_nb;
      bus.out_force_x <= bus.pipe_force_x;
      bus.out_force_y <= bus.pipe_force_y;
      bus.out_force_z <= bus.pipe_force_z;
      bus.misalign_error <= bus.misalign_error | (tail_v != bus.pipe_out_valid);
      if (emit) begin
        first <= 1'b0;
        last_ref <= tail_ref;
        bus.out_pair_count <= new_ref ? PAIR_CNT_WIDTH'(1)
                                      : bus.out_pair_count + PAIR_CNT_WIDTH'(~&bus.out_pair_count);
      end
    end
endmodule
